// File: rtl/zrtc_glyph_addr_seq.sv
// rtl/zrtc_glyph_addr_seq.sv - glyph ROM address sequencer for one row of RTC characters
//
// Snapshots a packed vector of BCD character codes on start, then streams every
// glyph-ROM word address of the row (char 0..NUM_CHARS-1, word 0..GLYPH_STRIDE-1
// within each char) over a valid/ready handshake.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   start       single-cycle frame request, honoured only when idle
//   lz_blank    blank char 0 when its code is 0 (captured with start)
//   digits      char c code at digits[4c+3:4c] (captured with start)
//   addr_ready  consumer accepts addr this cycle
//   addr_valid  addr holds a valid address
//   addr        glyph ROM word address (registered)
//   char_idx    character index of the current addr
//   busy        frame in progress
//   done        one-cycle pulse after the last beat is accepted
module zrtc_glyph_addr_seq #(
  parameter int NUM_CHARS    = 8,
  parameter int ADDR_W       = 11,
  parameter int GLYPH_BASE   = 1024,
  parameter int GLYPH_STRIDE = 36,
  parameter int COLON_CODE   = 10,
  parameter int BLANK_CODE   = 11,
  parameter logic [NUM_CHARS-1:0] SEP_MASK = 8'h24,
  localparam int CW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   lz_blank,
  input  logic [NUM_CHARS*4-1:0] digits,
  input  logic                   addr_ready,
  output logic                   addr_valid,
  output logic [ADDR_W-1:0]      addr,
  output logic [CW-1:0]          char_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int WW = (GLYPH_STRIDE > 1) ? $clog2(GLYPH_STRIDE) : 1;
  localparam logic [WW-1:0] WORD_LAST = WW'(GLYPH_STRIDE - 1);
  localparam logic [CW-1:0] CHAR_LAST = CW'(NUM_CHARS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [WW-1:0]            word, word_nxt;
  logic [CW-1:0]            char_nxt;
  logic [ADDR_W-1:0]        addr_nxt;
  logic [NUM_CHARS*4-1:0]   snap, snap_nxt;
  logic                     lz_q, lz_nxt;
  logic [CW-1:0]            char_inc;
  logic                     last_beat;

  // Glyph code actually displayed for a character position.
  function automatic logic [3:0] sel_code(input logic [CW-1:0] c, input logic [3:0] raw,
                                          input logic lz);
    if (SEP_MASK[c])
      return 4'(COLON_CODE);
    else if (c == '0 && lz && raw == 4'd0)
      return 4'(BLANK_CODE);
    else if (raw <= 4'd10)
      return raw;
    else
      return 4'd0;
  endfunction

  function automatic logic [ADDR_W-1:0] glyph_addr(input logic [3:0] code);
    return ADDR_W'(GLYPH_BASE) + ADDR_W'(code) * ADDR_W'(GLYPH_STRIDE);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      word     <= '0;
      char_idx <= '0;
      addr     <= '0;
      snap     <= '0;
      lz_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      word     <= word_nxt;
      char_idx <= char_nxt;
      addr     <= addr_nxt;
      snap     <= snap_nxt;
      lz_q     <= lz_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    word_nxt   = word;
    char_nxt   = char_idx;
    addr_nxt   = addr;
    snap_nxt   = snap;
    lz_nxt     = lz_q;
    char_inc   = char_idx + CW'(1);
    last_beat  = (word == WORD_LAST) && (char_idx == CHAR_LAST);
    addr_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          snap_nxt  = digits;
          lz_nxt    = lz_blank;
          word_nxt  = '0;
          char_nxt  = '0;
          // First address comes straight from the live inputs; it is registered here,
          // so the output itself never sees a combinational path from digits.
          addr_nxt  = glyph_addr(sel_code('0, digits[3:0], lz_blank));
        end
      end
      S_RUN: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
        if (addr_ready) begin
          if (last_beat) begin
            state_nxt = S_DONE;
            word_nxt  = '0;
            char_nxt  = '0;
          end else if (word == WORD_LAST) begin
            word_nxt = '0;
            char_nxt = char_inc;
            addr_nxt = glyph_addr(sel_code(char_inc, snap[4*int'(char_inc) +: 4], lz_q));
          end else begin
            // Words of one glyph are contiguous, so stepping the address is enough.
            word_nxt = word + WW'(1);
            addr_nxt = addr + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_zrtc_glyph_addr_seq.sv
// tb/tb_zrtc_glyph_addr_seq.sv - self-checking bench for zrtc_glyph_addr_seq
module tb_zrtc_glyph_addr_seq;

  localparam int NC   = 8;
  localparam int AW   = 11;
  localparam int BASE = 1024;
  localparam int STR  = 36;
  localparam int COL  = 10;
  localparam int BLK  = 11;
  localparam logic [7:0] SEP = 8'h24;
  localparam int BEATS = NC * STR;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          lz_blank;
  logic [31:0]   digits;
  logic          addr_ready;
  logic          addr_valid;
  logic [AW-1:0] addr;
  logic [2:0]    char_idx;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int cap [BEATS];

  zrtc_glyph_addr_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .lz_blank   (lz_blank),
    .digits     (digits),
    .addr_ready (addr_ready),
    .addr_valid (addr_valid),
    .addr       (addr),
    .char_idx   (char_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference: address of beat n from the display rules, using plain arithmetic.
  function automatic int model_addr(input logic [31:0] d, input logic lz, input int beat);
    int c;
    int w;
    int code;
    c    = beat / STR;
    w    = beat % STR;
    code = int'((d >> (4 * c)) & 32'hF);
    if (SEP[c])                         code = COL;
    else if (c == 0 && lz && code == 0) code = BLK;
    else if (code > 10)                 code = 0;
    return (BASE + code * STR + w) % (1 << AW);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge. Requests a frame, follows it to the last beat and the
  // done pulse, and returns #1 after the edge that ends the DONE cycle.
  task automatic run_frame(input string tag, input logic [31:0] d, input logic lz,
                           input int pready, input logic change_mid, input logic pulse_start);
    int beat;
    int cyc;
    logic stalled;
    int held_addr;
    int held_char;
    logic [31:0] d_ref;
    d_ref    = d;
    digits   = d;
    lz_blank = lz;
    start    = 1'b1;
    @(negedge clk);
    chk({tag, "_pre_valid"}, int'(addr_valid), 0);
    chk({tag, "_pre_done"}, int'(done), 0);
    @(posedge clk); #1;
    start   = 1'b0;
    beat    = 0;
    cyc     = 0;
    stalled = 1'b0;
    held_addr = 0;
    held_char = 0;
    while (beat < BEATS && cyc < 4000) begin
      addr_ready = ($urandom_range(99) < pready);
      if (pulse_start) start = ($urandom_range(3) == 0);
      @(negedge clk);
      if (addr_valid !== 1'b1) begin
        chk({tag, "_valid_in_run"}, int'(addr_valid), 1);
        break;
      end
      if (stalled) begin
        chk({tag, "_stall_addr"}, int'(addr), held_addr);
        chk({tag, "_stall_char"}, int'(char_idx), held_char);
      end
      if (busy !== 1'b1) chk({tag, "_busy"}, int'(busy), 1);
      if (done !== 1'b0) chk({tag, "_done_early"}, int'(done), 0);
      if (addr_ready) begin
        cap[beat] = int'(addr);
        chk({tag, "_addr"}, int'(addr), model_addr(d_ref, lz, beat));
        chk({tag, "_char"}, int'(char_idx), beat / STR);
        beat++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        held_addr = int'(addr);
        held_char = int'(char_idx);
      end
      if (change_mid && beat == 50) digits = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_beat_count"}, beat, BEATS);
    // Cycle after the last accept: DONE. A start here must be ignored.
    start = pulse_start;
    @(negedge clk);
    chk({tag, "_post_valid"}, int'(addr_valid), 0);
    chk({tag, "_post_busy"}, int'(busy), 0);
    chk({tag, "_post_done"}, int'(done), 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    lz_blank   = 1'b0;
    digits     = 32'h0;
    addr_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_valid", int'(addr_valid), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_char", int'(char_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: 12:34:56 at full rate
    run_frame("t1", 32'h6504_3021, 1'b0, 100, 1'b0, 1'b0);
    chk("t1_beat0", cap[0], 1060);
    chk("t1_beat36", cap[36], 1096);
    chk("t1_beat72", cap[72], 1384);
    chk("t1_beat287", cap[287], 1275);
    @(negedge clk);
    chk("t1_done_once", int'(done), 0);
    @(posedge clk); #1;

    // T2: same frame with random backpressure
    run_frame("t2", 32'h6504_3021, 1'b0, 50, 1'b0, 1'b0);
    chk("t2_beat287", cap[287], 1275);

    // T3: leading-zero blanking on and off
    run_frame("t3a", 32'h6504_3020, 1'b1, 100, 1'b0, 1'b0);
    chk("t3a_beat0", cap[0], 1420);
    chk("t3a_beat35", cap[35], 1455);
    run_frame("t3b", 32'h6504_3020, 1'b0, 70, 1'b0, 1'b0);
    chk("t3b_beat0", cap[0], 1024);
    chk("t3b_beat35", cap[35], 1059);

    // T4: illegal code maps to glyph 0, digits changed mid-frame
    run_frame("t4", 32'h6504_F021, 1'b0, 60, 1'b1, 1'b0);
    chk("t4_beat108", cap[108], 1024);
    chk("t4_beat143", cap[143], 1059);

    // T5: start pulses in RUN and DONE, next frame requested right after DONE
    run_frame("t5", $urandom, 1'b1, 50, 1'b0, 1'b1);
    run_frame("t5b", $urandom, $urandom_range(1), 80, 1'b0, 1'b0);

    // Random frames
    for (int i = 0; i < 3; i++) begin
      run_frame("rnd", $urandom, $urandom_range(1), $urandom_range(30, 100), 1'b1, 1'b1);
    end

    // T6: reset in the middle of a frame
    digits     = 32'h6504_3021;
    lz_blank   = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    addr_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", int'(addr_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_addr", int'(addr), 0);
    chk("t6_char", int'(char_idx), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done !== 1'b0 || addr_valid !== 1'b0) begin
        chk("t6_quiet_done", int'(done), 0);
        chk("t6_quiet_valid", int'(addr_valid), 0);
      end
    end
    @(posedge clk); #1;
    run_frame("t6r", 32'h6504_3021, 1'b0, 100, 1'b0, 1'b0);
    chk("t6r_beat0", cap[0], 1060);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
